// File: rtl/mux16_rr_sched_pkg.sv
// Shared types and constants for the 16-requester round-robin mux scheduler.
// Also holds a one-hot decode helper used by the top level.
package mux16_rr_sched_pkg;

   typedef enum logic {IDLE, XFER} state_e;

   localparam int NREQ  = 16;
   localparam int SEL_W = 4;

   function automatic logic [NREQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
      onehot16      = '0;
      onehot16[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/mux16_rr_sched_if.sv
// Request/data side and downstream valid/ready side of the scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface mux16_rr_sched_if;
   import mux16_rr_sched_pkg::*;

   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  data;
   logic [SEL_W-1:0] sel;
   logic [NREQ-1:0]  grant;
   logic [NREQ-1:0]  ack;
   logic             out_valid;
   logic             out_data;
   logic             out_ready;

   modport master (
      output req, data, out_ready,
      input  sel, grant, ack, out_valid, out_data
   );

   modport slave (
      input  req, data, out_ready,
      output sel, grant, ack, out_valid, out_data
   );
endinterface

// File: rtl/mux16_rr_sched_rr_pick16.sv
// Combinational round-robin picker: first set request scanning upward from ptr,
// wrapping 15 to 0.
module rr_pick16
   import mux16_rr_sched_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] k;

   // Walk from the farthest offset back to ptr so the nearest hit wins.
   always_comb begin
      any = 1'b0;
      idx = '0;
      k   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         k = ptr + 4'(i);
         if (req[k]) begin
            any = 1'b1;
            idx = k;
         end
      end
   end

endmodule

// File: rtl/mux_16cross1.sv
// Shared 16:1 single-bit mux tree, one select bit per level.
module mux_16cross1 (
   input  logic [15:0] d,
   input  logic [3:0]  s,
   output logic        y
);

   logic [7:0] l1;
   logic [3:0] l2;
   logic [1:0] l3;

   always_comb begin
      for (int i = 0; i < 8; i++) l1[i] = s[0] ? d[2*i+1]  : d[2*i];
      for (int i = 0; i < 4; i++) l2[i] = s[1] ? l1[2*i+1] : l1[2*i];
      for (int i = 0; i < 2; i++) l3[i] = s[2] ? l2[2*i+1] : l2[2*i];
      y = s[3] ? l3[1] : l3[0];
   end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 mux between 16 requesters, with a
// valid/ready output stage, transfer counter and sticky stall flag.
module mux16_rr_sched
   import mux16_rr_sched_pkg::*;
#(
   parameter int STALL_LIMIT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   mux16_rr_sched_if.slave  bus,
   output logic [CNT_W-1:0] xfer_cnt,
   output logic             stall_err
);

   localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

   state_e           state_q,     state_d;
   logic [SEL_W-1:0] sel_q,       sel_d;
   logic [NREQ-1:0]  grant_q,     grant_d;
   logic             out_valid_q, out_valid_d;
   logic             out_data_q,  out_data_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;
   logic [CNT_W-1:0] xfer_cnt_q,  xfer_cnt_d;
   logic [15:0]      stall_cnt_q, stall_cnt_d;
   logic             stall_err_q, stall_err_d;

   logic             any_idle, any_b2b, hs, load;
   logic [SEL_W-1:0] idx_idle, idx_b2b, sel_next_hs;
   logic             mux_y;
   logic [NREQ-1:0]  ack_c;

   assign hs          = out_valid_q & bus.out_ready;
   assign sel_next_hs = sel_q + 4'd1;

   rr_pick16 u_pick_idle (
      .req (bus.req),
      .ptr (ptr_q),
      .any (any_idle),
      .idx (idx_idle)
   );

   // Back-to-back pick: the current winner is masked and the scan starts just past it.
   rr_pick16 u_pick_b2b (
      .req (bus.req & ~onehot16(sel_q)),
      .ptr (sel_next_hs),
      .any (any_b2b),
      .idx (idx_b2b)
   );

   assign load  = (state_q == IDLE) ? any_idle : (hs & any_b2b);
   assign sel_d = !load ? sel_q : ((state_q == IDLE) ? idx_idle : idx_b2b);

   mux_16cross1 u_mux (
      .d (bus.data),
      .s (sel_d),
      .y (mux_y)
   );

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      ptr_d       = ptr_q;
      xfer_cnt_d  = xfer_cnt_q;
      stall_cnt_d = stall_cnt_q;
      stall_err_d = stall_err_q;
      ack_c       = '0;

      if (load) begin
         grant_d     = onehot16(sel_d);
         out_data_d  = mux_y;
         out_valid_d = 1'b1;
         state_d     = XFER;
      end

      if (state_q == XFER) begin
         if (hs) begin
            ack_c       = onehot16(sel_q);
            xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
            ptr_d       = sel_next_hs;
            stall_cnt_d = '0;
            if (!any_b2b) begin
               grant_d     = '0;
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end else begin
            if (stall_cnt_q < LIMIT) stall_cnt_d = stall_cnt_q + 16'd1;
            if (stall_cnt_d >= LIMIT) stall_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         grant_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
         ptr_q       <= '0;
         xfer_cnt_q  <= '0;
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         grant_q     <= grant_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         ptr_q       <= ptr_d;
         xfer_cnt_q  <= xfer_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   // A reset landing on a handshake cycle must not leak an ack pulse.
   assign bus.ack       = rst ? '0 : ack_c;
   assign bus.sel       = sel_q;
   assign bus.grant     = grant_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign xfer_cnt      = xfer_cnt_q;
   assign stall_err     = stall_err_q;

endmodule
